// File: rtl/balloon_pkg.sv
// Shared types and constants for the balloon sprite sequencers.
package balloon_pkg;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ERASE = 3'd2,
    ST_LOAD  = 3'd3,
    ST_MOVE  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int SPRITE_DIM = 16;

  localparam logic [7:0] LFSR_SEED    = 8'hA5;
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;  // taps 8,6,5,4, right-shifting Galois form
  localparam logic [7:0] SPAWN_X_BASE = 8'd16;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/balloon_motion_sequencer_pass_counter.sv
// 8-bit pass counter; wrap_o flags the last of 256 counted cycles.
module pass_counter (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic run_i,
  output logic wrap_o
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || start_i) begin
      count_q <= 8'd0;
    end else if (run_i) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign wrap_o = run_i && (count_q == 8'hFF);

endmodule

// File: rtl/balloon_motion_sequencer.sv
// Per-frame erase / move command sequencer for balloon_sprite_control.
// BALLOON_RANDOM_SPAWN_EN selects an LFSR-randomised respawn column.
module balloon_motion_sequencer
  import balloon_pkg::*;
#(
  parameter logic [7:0] SPAWN_X   = 8'((SCREEN_W - SPRITE_DIM) / 2),
  parameter logic [6:0] SPAWN_Y   = 7'(SCREEN_H - SPRITE_DIM),
  parameter int         TOP_LIMIT = 2
`ifdef BALLOON_RANDOM_SPAWN_EN
  ,
  parameter int         X_SPAN    = 128
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [3:0] speed,
  input  logic       sprite_complete,
  input  logic [7:0] pos_x,
  input  logic [6:0] pos_y,
  output logic       draw,
  output logic       clear,
  output logic       shift_h,
  output logic       shift_v,
  output logic       load,
  output logic [6:0] shift_amount,
  output logic [7:0] load_x,
  output logic [6:0] load_y,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  state_e     state_q;
  logic       respawn_q;
  logic [3:0] spd_q;
  logic       draw_q, clear_q, shift_v_q, load_q, plot_q, busy_q, done_q, ovr_q;
  logic [6:0] shamt_q;
  logic [7:0] load_x_q;

  logic       run, start, wrap, respawn_now;
  logic [6:0] move_shamt;
  logic [7:0] spawn_x;
  logic       unused_pos_x;

  assign run         = (state_q == ST_ERASE) || (state_q == ST_MOVE);
  assign start       = (state_q == ST_IDLE) && frame_tick && enable;
  assign respawn_now = {1'b0, pos_y} <= (8'(TOP_LIMIT) + {4'd0, speed});
  // Sprite y wraps mod 128, so the two's complement of spd moves the balloon up.
  assign move_shamt  = (respawn_q || (spd_q == 4'd0)) ? 7'd0 : (7'd0 - {3'd0, spd_q});
  assign unused_pos_x = ^pos_x;

  pass_counter u_pass_counter (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .run_i   (run),
    .wrap_o  (wrap)
  );

`ifdef BALLOON_RANDOM_SPAWN_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d  = lfsr_next(lfsr_q);
  assign spawn_x = SPAWN_X_BASE + 8'(lfsr_q % X_SPAN);

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign spawn_x = SPAWN_X;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SYNC;
      respawn_q <= 1'b0;
      spd_q     <= 4'd0;
      draw_q    <= 1'b0;
      clear_q   <= 1'b0;
      shift_v_q <= 1'b0;
      load_q    <= 1'b0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      shamt_q   <= 7'd0;
      load_x_q  <= SPAWN_X;
    end else begin
      ovr_q     <= frame_tick && (state_q != ST_IDLE);
      draw_q    <= 1'b0;
      clear_q   <= 1'b0;
      shift_v_q <= 1'b0;
      load_q    <= 1'b0;
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
      shamt_q   <= 7'd0;
      busy_q    <= 1'b1;
      case (state_q)
        ST_SYNC: begin
          if (sprite_complete) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            {draw_q, clear_q, plot_q} <= 3'b111;
          end
        end
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_ERASE;
            respawn_q <= respawn_now;
            spd_q     <= speed;
            {draw_q, clear_q, plot_q} <= 3'b111;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_ERASE: begin
          if (wrap && respawn_q) begin
            state_q  <= ST_LOAD;
            load_q   <= 1'b1;
            draw_q   <= 1'b1;
            load_x_q <= spawn_x;
          end else if (wrap) begin
            state_q <= ST_MOVE;
            {draw_q, shift_v_q, plot_q} <= 3'b111;
            shamt_q <= move_shamt;
          end else begin
            {draw_q, clear_q, plot_q} <= 3'b111;
          end
        end
        ST_LOAD: begin
          state_q <= ST_MOVE;
          {draw_q, shift_v_q, plot_q} <= 3'b111;
          shamt_q <= move_shamt;
        end
        ST_MOVE: begin
          if (wrap) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            {draw_q, shift_v_q, plot_q} <= 3'b111;
            shamt_q <= move_shamt;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_SYNC;
        end
      endcase
    end
  end

  assign draw         = draw_q;
  assign clear        = clear_q;
  assign shift_h      = 1'b0;
  assign shift_v      = shift_v_q;
  assign load         = load_q;
  assign shift_amount = shamt_q;
  assign load_x       = load_x_q;
  assign load_y       = SPAWN_Y;
  assign plot         = plot_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_balloon_motion_sequencer.sv
// Bench for balloon_motion_sequencer: sprite-block stand-in, frame-schedule model, directed and random frames.
module tb_balloon_motion_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0, frame_tick = 1'b0, enable = 1'b0;
  logic [3:0] speed = 4'd0;
  logic       draw, clear, shift_h, shift_v, load, plot, busy, frame_done, overrun;
  logic [6:0] shift_amount, load_y;
  logic [7:0] load_x;

  logic [7:0] s_ptr = 8'd0;
  logic [7:0] s_x = 8'd72;
  logic [6:0] s_y = 7'd52;
  logic       fy_en = 1'b0;
  logic [6:0] fy = 7'd0;
  logic       sprite_complete;
  assign sprite_complete = (s_ptr == 8'd0);

  int total = 0, bad = 0, fail_prints = 0, cyc = 0;

  always #5 clk = ~clk;

  balloon_motion_sequencer dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable), .speed(speed),
    .sprite_complete(sprite_complete), .pos_x(s_x), .pos_y(s_y),
    .draw(draw), .clear(clear), .shift_h(shift_h), .shift_v(shift_v), .load(load),
    .shift_amount(shift_amount), .load_x(load_x), .load_y(load_y), .plot(plot),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  // Sprite block stand-in: pixel pointer and position update on negedge.
  always @(negedge clk) begin
    if (fy_en) s_y = fy;
    else if (load === 1'b1) begin
      s_x = load_x;
      s_y = load_y;
    end else if (draw === 1'b1) begin
      if (shift_v === 1'b1 && s_ptr == 8'hFF) s_y = s_y + shift_amount;
      s_ptr = s_ptr + 8'd1;
    end
  end

  // Frame-schedule model: an accepted tick opens a window of erase/load/move/done offsets.
  bit model_ok = 0, m_sync = 0, m_active = 0, m_resp = 0;
  int m_off = 0, m_len = 0, m_spd = 0;

  function automatic logic [30:0] mk(input bit d, c, sv, ld, input int sa, input bit pl, bs, fd, ov);
    return {d, c, 1'b0, sv, ld, 7'(sa), 8'd72, 7'd104, pl, bs, fd, ov};
  endfunction

  always @(posedge clk) begin
    logic [30:0] e, a;
    bit ov;
    #1;
    cyc++;
    ov = frame_tick && (m_sync || m_active) && !reset;
    if (reset) begin
      model_ok = 1; m_sync = 1; m_active = 0;
    end else if (m_sync) begin
      if (s_ptr == 8'd0) m_sync = 0;
    end else if (m_active) begin
      m_off++;
      if (m_off > m_len) m_active = 0;
    end else if (frame_tick && enable) begin
      m_active = 1; m_off = 1; m_spd = int'(speed);
      m_resp = (int'(s_y) <= 2 + int'(speed));
      m_len = m_resp ? 514 : 513;
    end
    if (reset)           e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    else if (m_sync)     e = mk(1, 1, 0, 0, 0, 1, 1, 0, ov);
    else if (!m_active)  e = mk(0, 0, 0, 0, 0, 0, 0, 0, ov);
    else if (m_off <= 256) e = mk(1, 1, 0, 0, 0, 1, 1, 0, ov);
    else if (m_resp && m_off == 257) e = mk(1, 0, 0, 1, 0, 0, 1, 0, ov);
    else if (m_off < m_len) e = mk(1, 0, 1, 0, (m_resp || m_spd == 0) ? 0 : (128 - m_spd) % 128, 1, 1, 0, ov);
    else                 e = mk(0, 0, 0, 0, 0, 0, 1, 1, ov);
    a = {draw, clear, shift_h, shift_v, load, shift_amount, load_x, load_y, plot, busy, frame_done, overrun};
    if (model_ok) begin
      total++;
      if (a !== e) begin
        bad++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL outputs cycle=%0d got=%h want=%h", cyc, a, e);
        end
      end
      if (m_active && (m_off == m_len || (m_resp && m_off == 257))) begin
        total++;
        if (s_ptr != 8'd0) begin
          bad++;
          $display("FAIL sprite_wrap cycle=%0d ptr=%0d want=0", cyc, s_ptr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
    $display("check %s got=%0d want=%0d", name, act, exp);
  endtask

  task automatic set_y(input int v);
    fy = 7'(v); fy_en = 1'b1; step(); fy_en = 1'b0;
  endtask

  task automatic run_pass(input int spd, output int n_er, n_mv, n_ld, done_at, ldy, sa);
    int n;
    n_er = 0; n_mv = 0; n_ld = 0; done_at = -1; ldy = -1; sa = -1;
    speed = 4'(spd); enable = 1'b1; frame_tick = 1'b1;
    step(); frame_tick = 1'b0; n = 2;
    for (int k = 0; k < 700 && done_at < 0; k++) begin
      if (draw && clear) n_er++;
      if (draw && shift_v) begin n_mv++; sa = int'(shift_amount); end
      if (load) begin n_ld++; ldy = int'(load_y); end
      if (frame_done) done_at = n;
      step(); n++;
    end
    $display("pass speed=%0d erase=%0d move=%0d load=%0d done_at=%0d y=%0d", spd, n_er, n_mv, n_ld, done_at, s_y);
  endtask

  initial begin
    int er, mv, ld, da, ly, sa, cnt, cnt2, ysave;
    bit sent;
    // Reset with the sprite pointer already at zero.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset_busy", int'(busy), 0);
    check("reset_draw", int'(draw), 0);
    check("reset_load_x", int'(load_x), 72);

    set_y(52);
    run_pass(3, er, mv, ld, da, ly, sa);
    check("p1_erase", er, 256); check("p1_move", mv, 256); check("p1_load", ld, 0);
    check("p1_done_at", da, 514); check("p1_shamt", sa, 125); check("p1_y", int'(s_y), 49);

    set_y(4);
    run_pass(3, er, mv, ld, da, ly, sa);
    check("p2_erase", er, 256); check("p2_load", ld, 1); check("p2_load_y", ly, 104);
    check("p2_move", mv, 256); check("p2_shamt", sa, 0); check("p2_done_at", da, 515);
    check("p2_y", int'(s_y), 104);

    // Second tick 100 cycles into the erase pass.
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    cnt = 0; cnt2 = 0; er = 0; sent = 0;
    for (int k = 0; k < 800; k++) begin
      if (draw && clear) er++;
      if (er == 100 && !sent) begin frame_tick = 1'b1; sent = 1; end
      else frame_tick = 1'b0;
      if (overrun) cnt++;
      if (frame_done) cnt2++;
      step();
    end
    frame_tick = 1'b0;
    check("ovr_pulses", cnt, 1); check("ovr_frame_done", cnt2, 1); check("ovr_y", int'(s_y), 101);

    // Reset 40 cycles into the move pass.
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    mv = 0;
    for (int k = 0; k < 700 && mv < 40; k++) begin
      if (draw && shift_v) mv++;
      if (mv < 40) step();
    end
    check("rst_move_seen", mv, 40);
    reset = 1'b1; step(); reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      if (draw && clear) cnt++;
      step();
    end
    check("sync_cycles", cnt, 216); check("sync_busy_end", int'(busy), 0);

    // Frozen game, then hover.
    enable = 1'b0; ysave = int'(s_y);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (busy) cnt++;
      step();
    end
    check("disabled_busy", cnt, 0); check("disabled_y", int'(s_y), ysave);
    set_y(60);
    run_pass(0, er, mv, ld, da, ly, sa);
    check("hover_shamt", sa, 0); check("hover_y", int'(s_y), 60); check("hover_done_at", da, 514);

    // Random frames, overlapping ticks, and occasional resets.
    for (int it = 0; it < 40; it++) begin
      int gap;
      gap = $urandom_range(1, 700);
      speed = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 4) != 0);
      repeat (gap) step();
      if ($urandom_range(0, 11) == 0) begin
        reset = 1'b1; step(); reset = 1'b0;
        $display("rand it=%0d reset ptr=%0d", it, s_ptr);
      end else begin
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        $display("rand it=%0d tick speed=%0d enable=%0d y=%0d", it, speed, enable, s_y);
      end
    end
    repeat (800) step();
    check("final_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/balloon_motion_sequencer.md
Name: balloon_motion_sequencer

Overview:
Upstream command sequencer for balloon_sprite_control. Once per frame tick it issues a 256-cycle erase pass, then a 256-cycle move/redraw pass that makes the balloon rise. When the balloon reaches the top of the screen it respawns it at the bottom. Its plot output drives the VGA adapter write-enable alongside the sprite block's x/y/colour outputs.

Parameters:
SPAWN_X, 72, default spawn column (8 bits)
SPAWN_Y, 104, spawn row (7 bits); bottom of 120-row screen minus the 16-row sprite
TOP_LIMIT, 2, balloon respawns once pos_y <= TOP_LIMIT + speed
X_SPAN, 128, spawn column range width; used only with the optional feature

Ports:
clk  in  1  system clock; all state on posedge
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame (60 Hz)
enable  in  1  game running; low = balloon frozen
speed  in  4  rows risen per frame; 0 = hover
sprite_complete  in  1  sprite block complete (pointer==0)
pos_x  in  8  sprite block posx
pos_y  in  7  sprite block posy
draw  out  1  to sprite block
clear  out  1  to sprite block
shift_h  out  1  to sprite block; tied 0 in this block
shift_v  out  1  to sprite block
load  out  1  to sprite block
shift_amount  out  7  to sprite block
load_x  out  8  to sprite block
load_y  out  7  to sprite block
plot  out  1  VGA write-enable; equals draw
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse when move pass ends
overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset values: all outputs 0; load_x=SPAWN_X; load_y=SPAWN_Y; state=SYNC; pass counter=0.
- States: SYNC, IDLE, ERASE, LOAD, MOVE, DONE.
- SYNC: re-aligns the sprite pointer after a reset.
  - sprite_complete=1 -> IDLE.
  - Otherwise assert draw=clear=1 each cycle until sprite_complete=1.
- IDLE:
  - frame_tick & enable -> ERASE.
  - At that edge, latch respawn = (pos_y <= TOP_LIMIT + speed), computed 8-bit unsigned.
  - At that edge, latch spd = speed.
- ERASE: draw=clear=1 for exactly 256 cycles, counted by an 8-bit counter starting at 0. On counter wrap -> LOAD if respawn, else MOVE.
- LOAD: one cycle with load=1, draw=1, load_x/load_y = spawn coordinates -> MOVE. draw is required by the sprite block for load; plot=0 in this state.
- MOVE: draw=shift_v=1 for 256 cycles.
  - shift_amount = (128 - spd) mod 128, i.e. the 7-bit two's complement of spd; the sprite's y arithmetic wraps mod 128, so this moves the balloon up by spd.
  - If respawn, or spd=0: shift_amount=0 (redraw in place).
  - On counter wrap -> DONE.
- DONE: frame_done=1 for one cycle -> IDLE.
- plot = draw in ERASE, MOVE and SYNC. The sprite block updates pixels on negedge, so pixel data is valid at the following posedge.
- frame_tick while busy: ignored; overrun=1 that cycle. There is no queueing.
- enable falling mid-pass: the current pass completes; the next tick is ignored.
- reset mid-pass: outputs go to 0 at the reset edge; SYNC then flushes the sprite pointer back to 0 (clear colour only).
- Consistency check: at each pass end the sprite block has wrapped, so sprite_complete=1 in the cycle after the last draw. A mismatch is a bench assertion, not an RTL error path.

Optional Feature:
BALLOON_RANDOM_SPAWN_EN
- Defined: an 8-bit Galois LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every clock. Spawn column = SPAWN_X_BASE + (lfsr mod X_SPAN), with SPAWN_X_BASE=16, captured on entry to LOAD.
- Undefined: spawn column = SPAWN_X; there is no LFSR.

Decomposition:
- Package balloon_pkg holds:
  - the state encoding (3 bits)
  - SCREEN_W=160, SCREEN_H=120, SPRITE_DIM=16
  - the LFSR seed and tap mask
- One natural sub-module, pass_counter: 8-bit counter with start/wrap pulse. It is reusable by other sprite sequencers.

Test Plan:
- Reset 3 cycles with sprite pointer at 0 -> SYNC exits in 1 cycle; IDLE; all outputs 0; busy=0.
- pos_y=52, speed=3, one frame_tick -> 256 cycles of draw&clear, then 256 of draw&shift_v with shift_amount=125; frame_done at cycle 514; sprite pos_y becomes 49.
- pos_y=4, speed=3 -> ERASE, then one load cycle with load_y=104, then MOVE with shift_amount=0; pos_y=104 afterwards.
- frame_tick at cycle 100 of ERASE -> overrun pulse; no extra pass; frame_done occurs only once.
- Reset asserted at cycle 40 of MOVE -> SYNC drives clear for 216 cycles until sprite_complete, then IDLE.
- speed=0 or enable=0 -> with enable=0 no passes run; with speed=0 the passes run with shift_amount=0 and the position is unchanged.
